// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and constants shared by the instruction-fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, FAULT = 2'd2} state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: picks the next PC and raises halt/fault requests for the fetch stage
module pc_next_sel import fetch_pkg::*; #(
    parameter int NUM_OF_INST = 1024
) (
    input  logic [31:0] pc,
    input  state_t      state,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        empty,
    output logic [31:0] next_pc,
    output logic        load_en,
    output logic        halt_req,
    output logic        fault_req
);
    localparam logic [31:0] LIMIT = 32'(NUM_OF_INST * 4);
    logic active, step, oob;
    always_comb begin
        active    = state != FAULT;
        step      = state == RUN && !redirect_valid && empty;
        next_pc   = redirect_valid ? redirect_target : pc + PC_STEP;
        oob       = next_pc >= LIMIT;
        // a misaligned target wins over the range check
        fault_req = active && redirect_valid && redirect_target[1:0] != 2'b00;
        halt_req  = active && !fault_req && (redirect_valid || step) && oob;
        load_en   = active && !fault_req && (redirect_valid || step) && !oob;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from inst_mem and holds one instruction for decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = fetch_pkg::RESET_PC,
    parameter int          NUM_OF_INST = 1024,
    parameter logic [31:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_address,
    input  logic [31:0] instruction_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);
    import fetch_pkg::state_t, fetch_pkg::RUN, fetch_pkg::HALT, fetch_pkg::FAULT;

    state_t      state, state_next;
    logic [31:0] pc, next_pc;
    logic        empty, fetch, flush, load_en, halt_req, fault_req;

    assign pc_address = pc;
    assign empty      = !out_valid || out_ready;
    assign flush      = redirect_valid && state != FAULT;
    assign fetch      = state == RUN && !redirect_valid && empty;

    pc_next_sel #(.NUM_OF_INST(NUM_OF_INST)) u_sel (
        .pc              (pc),
        .state           (state),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .empty           (empty),
        .next_pc         (next_pc),
        .load_en         (load_en),
        .halt_req        (halt_req),
        .fault_req       (fault_req)
    );

    always_ff @(posedge clk)
        state <= rst ? RUN : state_next;

    always_comb
        state_next = fault_req ? FAULT : halt_req ? HALT : load_en ? RUN : state;

    always_comb begin
        halted = state == HALT;
        fault  = state == FAULT;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (load_en)
            pc <= next_pc;
    end

    // the register drains to NOP whenever nothing new is loaded into a free slot
    always_ff @(posedge clk) begin
        if (rst || flush || (!fetch && out_ready)) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_instruction <= NOP_INSTR;
        end else if (fetch) begin
            out_valid       <= 1'b1;
            out_pc          <= pc;
            out_instruction <= instruction_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            fetch_count <= '0;
        else if (out_valid && out_ready)
            fetch_count <= fetch_count + 32'd1;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench; the model is the expected program-order stream
module tb_fetch_unit;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic        clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] instruction_in, pc_address, out_pc, out_instruction, fetch_count;
    logic        out_valid, halted, fault;
    logic [31:0] mem [DEPTH];

    typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0, m_cnt = 0;
    bit   faulted = 1'b0;

    always #5 clk = ~clk;
    assign instruction_in = pc_address < LIMIT ? mem[pc_address[11:2]] : NOP;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_address      (pc_address),
        .instruction_in  (instruction_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .halted          (halted),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // everything from a start address to the end of memory is what decode should see next
    task automatic push_run(input logic [31:0] start);
        for (logic [31:0] a = start; a < LIMIT; a += 32'd4)
            q.push_back('{a, mem[a[11:2]]});
    endtask

    task automatic model_reset();
        faulted = 1'b0;
        q.delete();
        push_run(32'h0);
    endtask

    task automatic model_redirect(input logic [31:0] t);
        if (faulted) return;
        q.delete();
        if (t[1:0] != 2'b00) faulted = 1'b1;
        else push_run(t);
    endtask

    // inputs apply to the next edge; on return the outputs show the previous cycle's effect
    task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r; out_ready = rdy; redirect_valid = rv; redirect_target = t;
        @(negedge clk);
        #1;
        if (r) model_reset();
        else if (rv) model_redirect(t);
    endtask

    initial forever begin
        @(negedge clk);
        chk("fetch_count", fetch_count, 32'(m_cnt));
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: got out_pc %h expected no valid output", out_pc);
            end else begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_instruction", out_instruction, q[0].ins);
                if (out_ready && !rst) void'(q.pop_front());
            end
        end else
            chk("idle_nop", out_instruction, NOP);
        if (rst) m_cnt = 0;
        else if (out_valid === 1'b1 && out_ready) m_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] t;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h0010_0033; mem[1] = 32'h0020_0113; mem[2] = 32'h0030_2193;
        mem[1023] = 32'h0040_4233;

        // reset values
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instruction, NOP);
        chk("rst_pc", out_pc, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_pc_address", pc_address, 0);

        // 1: back-to-back fetch
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        chk("t1_pc0", out_pc, 32'h0); chk("t1_ins0", out_instruction, 32'h0010_0033);
        cyc(0, 1, 0, 0);
        chk("t1_pc4", out_pc, 32'h4); chk("t1_ins4", out_instruction, 32'h0020_0113);
        cyc(0, 1, 0, 0);
        chk("t1_pc8", out_pc, 32'h8); chk("t1_ins8", out_instruction, 32'h0030_2193);
        cyc(0, 0, 0, 0);
        chk("t1_count", fetch_count, 32'd3);

        // 2: stall at out_pc=4
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("t2_stall_pc", out_pc, 32'h4);
            chk("t2_stall_ins", out_instruction, 32'h0020_0113);
            chk("t2_stall_pc_address", pc_address, 32'h8);
            chk("t2_stall_valid", 32'(out_valid), 1);
        end
        cyc(0, 1, 0, 0);
        chk("t2_release_pc", out_pc, 32'h4);
        cyc(0, 1, 0, 0);
        chk("t2_next_pc", out_pc, 32'h8);

        // 3: redirect while a handshake completes
        cyc(0, 1, 1, 32'h100);
        cyc(0, 1, 0, 0);
        chk("t3_flush_valid", 32'(out_valid), 0);
        chk("t3_flush_instr", out_instruction, NOP);
        chk("t3_count", fetch_count, 32'd4);
        cyc(0, 1, 0, 0);
        chk("t3_target_pc", out_pc, 32'h100);
        chk("t3_target_valid", 32'(out_valid), 1);

        // 4: run off the end, halt, redirect back
        cyc(0, 1, 1, 32'hF00);
        n = 0;
        do begin cyc(0, 1, 0, 0); n++; end
        while (!(out_valid === 1'b1 && out_pc === 32'hFFC) && n < 200);
        chk("t4_reach_ffc", out_pc, 32'hFFC);
        chk("t4_last_ins", out_instruction, 32'h0040_4233);
        cyc(0, 1, 0, 0);
        chk("t4_halted", 32'(halted), 1);
        chk("t4_valid", 32'(out_valid), 0);
        chk("t4_pc_address", pc_address, 32'hFFC);
        cyc(0, 1, 1, 32'h0);
        cyc(0, 1, 0, 0);
        chk("t4_unhalt", 32'(halted), 0);
        cyc(0, 1, 0, 0);
        chk("t4_restart_pc", out_pc, 32'h0);
        chk("t4_restart_valid", 32'(out_valid), 1);

        // 5: misaligned target faults; later redirects ignored
        cyc(0, 1, 1, 32'h102);
        cyc(0, 1, 0, 0);
        chk("t5_fault", 32'(fault), 1);
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_pc_address", pc_address, 32'h8);
        cyc(0, 1, 1, 32'h0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        chk("t5_sticky", 32'(fault), 1);
        chk("t5_frozen", pc_address, 32'h8);
        chk("t5_still_idle", 32'(out_valid), 0);
        cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t5_rst_fault", 32'(fault), 0);
        chk("t5_rst_pc", pc_address, 32'h0);

        // 6: reset in the middle of a stall
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t6_stalled", out_pc, 32'h4);
        cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_pc", out_pc, 0);
        chk("t6_instr", out_instruction, NOP);
        chk("t6_count", fetch_count, 0);
        chk("t6_pc_address", pc_address, 0);
        chk("t6_halted", 32'(halted), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            t = sel == 0 ? 32'(LIMIT + 32'(4 * $urandom_range(0, 15)))
              : sel < 4  ? 32'(LIMIT - 32'(4 * $urandom_range(1, 12)))
              :            32'(4 * $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 59) == 0) t[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 24) == 0, t);
        end
        cyc(0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
